// File: rtl/pb_gesture_decoder.sv
// pb_gesture_decoder
//   Classifies debounced push-button activity into three gestures: short press,
//   long press and double click. Timing runs on a prescaled tick so thresholds
//   are counted in ticks rather than raw clock cycles.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   pb_state      debounced button level, 1 = held
//   pb_down       1-cycle pulse on the debounced press edge
//   pb_up         1-cycle pulse on the debounced release edge
//   short_press   1-cycle pulse: single press, released early, no second press
//   long_press    1-cycle pulse: button held for LONG_TICKS ticks
//   double_click  1-cycle pulse: second press released
//   held_long     level, high while the long press is still being held
//   busy          level, high whenever a gesture is in progress
//
// Handshake: none. pb_down/pb_up are single-cycle strobes sampled on every
// clock; asserting both in the same cycle makes that cycle carry no edge.
module pb_gesture_decoder #(
    parameter int TICK_DIV     = 50000,
    parameter int LONG_TICKS   = 800,
    parameter int DCLICK_TICKS = 250,
    parameter int TMR_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_state,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held_long,
    output logic busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0] LONG_LAST  = TMR_W'(LONG_TICKS - 1);
    localparam logic [TMR_W-1:0] DCLK_LAST  = TMR_W'(DCLICK_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT_2ND  = 3'd3,
        S_PRESSED2  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    presc;
    logic [TMR_W-1:0] timer;

    logic tick;
    logic dn;
    logic up;

    logic short_d;
    logic long_d;
    logic dbl_d;
    logic held_d;
    logic busy_d;

    // Simultaneous press and release edges cancel each other out.
    assign dn   = pb_down & ~pb_up;
    assign up   = pb_up & ~pb_down;
    assign tick = (presc == PRESC_LAST);

    // State register, timebase and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            presc        <= '0;
            timer        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            held_long    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            short_press  <= short_d;
            long_press   <= long_d;
            double_click <= dbl_d;
            held_long    <= held_d;
            busy         <= busy_d;
            // Restart the timebase on every transition so each state measures
            // its own interval from a known phase.
            if (state_next != state) begin
                presc <= '0;
                timer <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && (timer != {TMR_W{1'b1}})) begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    // Next-state logic. Release/press edges take priority over a timeout that
    // lands in the same cycle; a level that drops without a release edge means
    // an edge was lost, so the gesture is abandoned silently.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dn) state_next = S_PRESSED;
            end
            S_PRESSED: begin
                if (up)                              state_next = S_WAIT_2ND;
                else if (!pb_state)                  state_next = S_IDLE;
                else if (tick && timer == LONG_LAST) state_next = S_LONG_HELD;
            end
            S_LONG_HELD: begin
                if (up || !pb_state) state_next = S_IDLE;
            end
            S_WAIT_2ND: begin
                if (dn)                              state_next = S_PRESSED2;
                else if (tick && timer == DCLK_LAST) state_next = S_IDLE;
            end
            S_PRESSED2: begin
                if (up || !pb_state) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode, registered above so every pulse lands one cycle after
    // its cause. WAIT_2ND only returns to IDLE on the double-click timeout.
    always_comb begin
        short_d = (state == S_WAIT_2ND) && (state_next == S_IDLE);
        long_d  = (state == S_PRESSED)  && (state_next == S_LONG_HELD);
        dbl_d   = (state == S_PRESSED2) && up;
        held_d  = (state_next == S_LONG_HELD);
        busy_d  = (state_next != S_IDLE);
    end

endmodule
